// File: rtl/rect_overlay_pkg.sv
// Purpose: shared widths, default colour and the box descriptor type for the overlay.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package rect_overlay_pkg;

  localparam int COORD_W = 10;
  localparam int PIX_W   = 12;

  localparam logic [PIX_W-1:0] COLOR_GREEN = 12'h0F0;

  // One box: inclusive inner edges, border colour and draw/blink flags.
  typedef struct packed {
    logic [COORD_W-1:0] left;
    logic [COORD_W-1:0] right;
    logic [COORD_W-1:0] top;
    logic [COORD_W-1:0] bottom;
    logic [PIX_W-1:0]   color;
    logic               enable;
    logic               blink;
  } box_desc_t;

endpackage

// File: rtl/rect_overlay_if.sv
// Purpose: groups the box-write port, pixel input stream and overlaid output stream.
// Latency: n/a (wiring only).
// Backpressure: none; every signal is a plain per-cycle strobe or data word.
interface rect_overlay_if #(
  parameter int NUM_BOX = 4
);
  import rect_overlay_pkg::*;

  localparam int IDX_W = (NUM_BOX > 1) ? $clog2(NUM_BOX) : 1;

  logic               box_wr_en;
  logic [IDX_W-1:0]   box_wr_idx;
  logic [COORD_W-1:0] box_left;
  logic [COORD_W-1:0] box_right;
  logic [COORD_W-1:0] box_top;
  logic [COORD_W-1:0] box_bottom;
  logic [PIX_W-1:0]   box_color;
  logic               box_enable;
  logic               box_blink;
  logic               frame_start;
  logic               pix_valid_in;
  logic [COORD_W-1:0] pixel_x;
  logic [COORD_W-1:0] pixel_y;
  logic [PIX_W-1:0]   pixel_in;
  logic               pix_valid_out;
  logic [PIX_W-1:0]   pixel_out;
  logic [NUM_BOX-1:0] box_hit;

  modport master (
    output box_wr_en, box_wr_idx, box_left, box_right, box_top, box_bottom,
           box_color, box_enable, box_blink, frame_start, pix_valid_in,
           pixel_x, pixel_y, pixel_in,
    input  pix_valid_out, pixel_out, box_hit
  );

  modport slave (
    input  box_wr_en, box_wr_idx, box_left, box_right, box_top, box_bottom,
           box_color, box_enable, box_blink, frame_start, pix_valid_in,
           pixel_x, pixel_y, pixel_in,
    output pix_valid_out, pixel_out, box_hit
  );

endinterface

// File: rtl/rect_border_hit.sv
// Purpose: decides whether a pixel lies on one box's border ring (outside the inner edges).
// Latency: purely combinational.
// Backpressure: none.
module rect_border_hit
  import rect_overlay_pkg::*;
#(
  parameter int BORDER_W = 5
) (
  input  box_desc_t          box_i,
  input  logic [COORD_W-1:0] pixel_x_i,
  input  logic [COORD_W-1:0] pixel_y_i,
  output logic               hit_o
);

  // Two extra bits keep left-BORDER_W below zero and right+BORDER_W above max from wrapping.
  localparam int SW = COORD_W + 2;

  logic signed [SW-1:0] x, y, l, r, t, b, bw;
  logic                 in_outer, in_inner, well_formed;

  assign x  = signed'({2'b00, pixel_x_i});
  assign y  = signed'({2'b00, pixel_y_i});
  assign l  = signed'({2'b00, box_i.left});
  assign r  = signed'({2'b00, box_i.right});
  assign t  = signed'({2'b00, box_i.top});
  assign b  = signed'({2'b00, box_i.bottom});
  assign bw = SW'(BORDER_W);

  assign well_formed = (l <= r) && (t <= b);
  assign in_outer    = (x >= l - bw) && (x <= r + bw) && (y >= t - bw) && (y <= b + bw);
  assign in_inner    = (x >= l) && (x <= r) && (y >= t) && (y <= b);
  assign hit_o       = box_i.enable && well_formed && in_outer && !in_inner;

endmodule

// File: rtl/rect_overlay.sv
// Purpose: draws up to NUM_BOX bordered boxes over the pixel stream with frame-synchronous box updates.
// Latency: fixed 2 cycles from pixel inputs to pixel_out/box_hit/pix_valid_out.
// Backpressure: none; accepts one pixel every cycle and never stalls.
module rect_overlay
  import rect_overlay_pkg::*;
#(
  parameter int NUM_BOX      = 4,
  parameter int BORDER_W     = 5,
  parameter int BLINK_FRAMES = 30
) (
  input  logic           clk,
  input  logic           rst,
  rect_overlay_if.slave  ovl
);

  localparam int BC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  box_desc_t          pend_q [NUM_BOX];
  box_desc_t          pend_d [NUM_BOX];
  box_desc_t          act_q  [NUM_BOX];
  box_desc_t          act_d  [NUM_BOX];
  box_desc_t          wr_desc;
  logic [BC_W-1:0]    blink_cnt_q, blink_cnt_d;
  logic               blink_phase_q, blink_phase_d;
  logic [NUM_BOX-1:0] raw_hit, gated_hit;
  logic [PIX_W-1:0]   sel_color;

  logic               s1_vld_q;
  logic [PIX_W-1:0]   s1_pix_q, s1_col_q;
  logic [NUM_BOX-1:0] s1_hit_q;
  logic               vld_q;
  logic [PIX_W-1:0]   pix_q;
  logic [NUM_BOX-1:0] hit_q;

  assign wr_desc = '{left:   ovl.box_left,   right:  ovl.box_right,
                     top:    ovl.box_top,    bottom: ovl.box_bottom,
                     color:  ovl.box_color,  enable: ovl.box_enable,
                     blink:  ovl.box_blink};

  // Bank next state: active takes the pre-write pending copy, so a same-cycle write waits a frame.
  always_comb begin
    pend_d = pend_q;
    act_d  = act_q;
    if (ovl.frame_start) act_d = pend_q;
    if (ovl.box_wr_en && (int'(ovl.box_wr_idx) < NUM_BOX)) pend_d[ovl.box_wr_idx] = wr_desc;
  end

  // Blink next state: count frame pulses and flip the phase each time the count wraps.
  always_comb begin
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    if (ovl.frame_start) begin
      if (blink_cnt_q == BC_W'(BLINK_FRAMES - 1)) begin
        blink_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end
  end

  for (genvar i = 0; i < NUM_BOX; i++) begin : g_box
    rect_border_hit #(.BORDER_W(BORDER_W)) u_hit (
      .box_i     (act_q[i]),
      .pixel_x_i (ovl.pixel_x),
      .pixel_y_i (ovl.pixel_y),
      .hit_o     (raw_hit[i])
    );
    assign gated_hit[i] = raw_hit[i] && ovl.pix_valid_in && !(blink_phase_q && act_q[i].blink);
  end

  // Lowest-index hitting box wins; colour is captured with the pixel so a bank swap cannot recolour it.
  always_comb begin
    sel_color = '0;
    for (int i = NUM_BOX - 1; i >= 0; i--) begin
      if (gated_hit[i]) sel_color = act_q[i].color;
    end
  end

  // Descriptor banks and blink state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_BOX; i++) begin
        pend_q[i] <= '0;
        act_q[i]  <= '0;
      end
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
    end else begin
      pend_q        <= pend_d;
      act_q         <= act_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
    end
  end

  // Two-stage pixel pipeline: stage 1 holds hits and chosen colour, stage 2 the final pixel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld_q <= 1'b0;
      s1_pix_q <= '0;
      s1_col_q <= '0;
      s1_hit_q <= '0;
      vld_q    <= 1'b0;
      pix_q    <= '0;
      hit_q    <= '0;
    end else begin
      s1_vld_q <= ovl.pix_valid_in;
      s1_pix_q <= ovl.pixel_in;
      s1_col_q <= sel_color;
      s1_hit_q <= gated_hit;
      vld_q    <= s1_vld_q;
      pix_q    <= !s1_vld_q ? '0 : ((|s1_hit_q) ? s1_col_q : s1_pix_q);
      hit_q    <= s1_hit_q;
    end
  end

  assign ovl.pix_valid_out = vld_q;
  assign ovl.pixel_out     = pix_q;
  assign ovl.box_hit       = hit_q;

endmodule

// File: tb/tb_rect_overlay.sv
// Purpose: checks rect_overlay against a frame-level behavioural model plus pinned literal cases.
// Latency: model expects outputs exactly 2 cycles after each sampled input.
// Backpressure: none; stimulus drives one pixel slot per cycle.
module tb_rect_overlay;
  import rect_overlay_pkg::*;

  localparam int NB = 4;
  localparam int BW = 5;
  localparam int BF = 2;
  localparam logic [PIX_W-1:0] RED  = 12'hF00;
  localparam logic [PIX_W-1:0] BLUE = 12'h00F;
  localparam logic [PIX_W-1:0] CYAN = 12'h0FF;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  rect_overlay_if #(.NUM_BOX(NB)) ovl_if ();

  rect_overlay #(.NUM_BOX(NB), .BORDER_W(BW), .BLINK_FRAMES(BF)) dut (
    .clk (clk),
    .rst (rst),
    .ovl (ovl_if)
  );

  int checks = 0;
  int errors = 0;
  bit cmp_on = 1'b0;

  // Model state: two banks, frame counter, and the expected output two slots deep.
  box_desc_t        m_pend [NB];
  box_desc_t        m_act  [NB];
  int               m_frames;
  logic             m_v1, m_v2;
  logic [PIX_W-1:0] m_p1, m_p2;
  logic [NB-1:0]    m_h1, m_h2;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected output for one pixel slot from the box rules, evaluated with plain integers.
  function automatic void model_pix(input int x, input int y, input logic [PIX_W-1:0] pin,
                                    input logic vld, output logic [PIX_W-1:0] po,
                                    output logic [NB-1:0] ho);
    bit suppress;
    bit found;
    int l, r, t, b;
    bit outer, inner, on;
    suppress = ((m_frames / BF) % 2) == 1;
    found = 0;
    ho = '0;
    po = vld ? pin : '0;
    for (int i = 0; i < NB; i++) begin
      l = int'(m_act[i].left);
      r = int'(m_act[i].right);
      t = int'(m_act[i].top);
      b = int'(m_act[i].bottom);
      outer = (x >= l - BW) && (x <= r + BW) && (y >= t - BW) && (y <= b + BW);
      inner = (x >= l) && (x <= r) && (y >= t) && (y <= b);
      on = vld && m_act[i].enable && (l <= r) && (t <= b) && outer && !inner &&
           !(suppress && m_act[i].blink);
      if (on) begin
        ho[i] = 1'b1;
        if (!found) begin
          po = m_act[i].color;
          found = 1;
        end
      end
    end
  endfunction

  // Reference model advances on every clock edge using the inputs held across it.
  always @(posedge clk) begin
    logic [PIX_W-1:0] p;
    logic [NB-1:0]    h;
    if (rst) begin
      for (int i = 0; i < NB; i++) begin
        m_pend[i] = '0;
        m_act[i]  = '0;
      end
      m_frames = 0;
      m_v1 = 0; m_v2 = 0; m_p1 = '0; m_p2 = '0; m_h1 = '0; m_h2 = '0;
    end else begin
      m_v2 = m_v1; m_p2 = m_p1; m_h2 = m_h1;
      model_pix(int'(ovl_if.pixel_x), int'(ovl_if.pixel_y), ovl_if.pixel_in,
                ovl_if.pix_valid_in, p, h);
      m_v1 = ovl_if.pix_valid_in; m_p1 = p; m_h1 = h;
      if (ovl_if.frame_start) begin
        for (int i = 0; i < NB; i++) m_act[i] = m_pend[i];
        m_frames++;
      end
      if (ovl_if.box_wr_en)
        m_pend[ovl_if.box_wr_idx] = '{left: ovl_if.box_left, right: ovl_if.box_right,
                                      top: ovl_if.box_top, bottom: ovl_if.box_bottom,
                                      color: ovl_if.box_color, enable: ovl_if.box_enable,
                                      blink: ovl_if.box_blink};
    end
  end

  // Every cycle, outputs must match the model (or be all zero while reset is held).
  always @(negedge clk) begin
    if (cmp_on) begin
      if (rst)
        check("reset_hold", 32'({ovl_if.pix_valid_out, ovl_if.pixel_out, ovl_if.box_hit}), 32'd0);
      else
        check("stream", 32'({ovl_if.pix_valid_out, ovl_if.pixel_out, ovl_if.box_hit}),
              32'({m_v2, m_p2, m_h2}));
    end
  end

  task automatic idle_inputs();
    ovl_if.box_wr_en    = 1'b0;
    ovl_if.box_wr_idx   = '0;
    ovl_if.box_left     = '0;
    ovl_if.box_right    = '0;
    ovl_if.box_top      = '0;
    ovl_if.box_bottom   = '0;
    ovl_if.box_color    = '0;
    ovl_if.box_enable   = 1'b0;
    ovl_if.box_blink    = 1'b0;
    ovl_if.frame_start  = 1'b0;
    ovl_if.pix_valid_in = 1'b0;
    ovl_if.pixel_x      = '0;
    ovl_if.pixel_y      = '0;
    ovl_if.pixel_in     = '0;
  endtask

  task automatic set_box(input int idx, input int l, input int r, input int t, input int b,
                         input logic [PIX_W-1:0] c, input logic en, input logic bl);
    ovl_if.box_wr_idx = 2'(idx);
    ovl_if.box_left   = COORD_W'(l);
    ovl_if.box_right  = COORD_W'(r);
    ovl_if.box_top    = COORD_W'(t);
    ovl_if.box_bottom = COORD_W'(b);
    ovl_if.box_color  = c;
    ovl_if.box_enable = en;
    ovl_if.box_blink  = bl;
  endtask

  task automatic wr_box(input int idx, input int l, input int r, input int t, input int b,
                        input logic [PIX_W-1:0] c, input logic en, input logic bl, input logic fs);
    @(posedge clk); #1;
    set_box(idx, l, r, t, b, c, en, bl);
    ovl_if.box_wr_en   = 1'b1;
    ovl_if.frame_start = fs;
    @(posedge clk); #1;
    ovl_if.box_wr_en   = 1'b0;
    ovl_if.frame_start = 1'b0;
  endtask

  task automatic frame();
    @(posedge clk); #1 ovl_if.frame_start = 1'b1;
    @(posedge clk); #1 ovl_if.frame_start = 1'b0;
  endtask

  // Single pixel in, then the output two edges later against a hand-worked value.
  task automatic lit(input string name, input int x, input int y, input logic [PIX_W-1:0] pin,
                     input logic [PIX_W-1:0] exp_pix, input logic [NB-1:0] exp_hit);
    @(posedge clk); #1;
    ovl_if.pix_valid_in = 1'b1;
    ovl_if.pixel_x      = COORD_W'(x);
    ovl_if.pixel_y      = COORD_W'(y);
    ovl_if.pixel_in     = pin;
    @(posedge clk); #1 ovl_if.pix_valid_in = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check(name, 32'({ovl_if.pix_valid_out, ovl_if.pixel_out, ovl_if.box_hit}),
          32'({1'b1, exp_pix, exp_hit}));
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int l, r, t, b;
    idle_inputs();
    #1 rst = 1'b1;
    cmp_on = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_state", 32'({ovl_if.pix_valid_out, ovl_if.pixel_out, ovl_if.box_hit}), 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    // Single green box: corner, just outside, inner, right border, beyond, far corner.
    wr_box(0, 100, 200, 50, 150, COLOR_GREEN, 1, 0, 0);
    frame();
    lit("b0_corner",       95,  50, 12'h123, COLOR_GREEN, 4'b0001);
    lit("b0_left_outside", 94,  50, 12'h456, 12'h456,     4'b0000);
    lit("b0_inner",       100, 100, 12'h789, 12'h789,     4'b0000);
    lit("b0_right_border",201, 100, 12'hABC, COLOR_GREEN, 4'b0001);
    lit("b0_beyond_right",206, 100, 12'hABD, 12'hABD,     4'b0000);
    lit("b0_far_corner",  205, 155, 12'h321, COLOR_GREEN, 4'b0001);

    // Box touching the origin: border clips at 0, nothing wraps to the far corner.
    wr_box(0, 2, 10, 0, 10, COLOR_GREEN, 1, 0, 0);
    frame();
    lit("clip_origin",   0,    0,    12'h111, COLOR_GREEN, 4'b0001);
    lit("no_wrap",       1020, 1020, 12'h222, 12'h222,     4'b0000);

    // Overlapping borders: box 0 wins the colour, both hit bits set.
    wr_box(0, 100, 200, 50, 150, RED, 1, 0, 0);
    wr_box(1, 150, 250, 100, 200, BLUE, 1, 0, 0);
    frame();
    lit("overlap_prio", 202,  97, 12'h555, RED,  4'b0011);
    lit("b1_only",      253, 150, 12'h556, BLUE, 4'b0010);

    // Mid-frame write holds until frame_start; same-cycle write lands one frame later.
    wr_box(1, 150, 250, 100, 200, COLOR_GREEN, 1, 0, 0);
    lit("midframe_hold",  253, 150, 12'h557, BLUE,        4'b0010);
    wr_box(1, 150, 250, 100, 200, CYAN, 1, 0, 1);
    lit("same_cycle_old", 253, 150, 12'h558, COLOR_GREEN, 4'b0010);
    frame();
    lit("same_cycle_new", 253, 150, 12'h559, CYAN,        4'b0010);

    // Blink with two frames per half-period.
    do_reset();
    wr_box(0, 100, 200, 50, 150, COLOR_GREEN, 1, 1, 0);
    frame();
    lit("blink_f1", 95, 50, 12'h601, COLOR_GREEN, 4'b0001);
    frame();
    lit("blink_f2", 95, 50, 12'h602, 12'h602,     4'b0000);
    frame();
    lit("blink_f3", 95, 50, 12'h603, 12'h603,     4'b0000);
    frame();
    lit("blink_f4", 95, 50, 12'h604, COLOR_GREEN, 4'b0001);

    // Reset in the middle of a stream of hitting pixels.
    @(posedge clk); #1;
    ovl_if.pix_valid_in = 1'b1;
    ovl_if.pixel_x      = COORD_W'(95);
    ovl_if.pixel_y      = COORD_W'(50);
    ovl_if.pixel_in     = 12'h700;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1 check("rst_immediate", 32'({ovl_if.pix_valid_out, ovl_if.pixel_out, ovl_if.box_hit}), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    ovl_if.pix_valid_in = 1'b0;
    lit("post_rst_passthru", 95, 50, 12'h777, 12'h777, 4'b0000);

    // Randomised traffic checked cycle by cycle against the model.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(posedge clk); #1;
      if (rst) rst = 1'b0;
      l = ($urandom_range(0, 9) == 0) ? 1000 + $urandom_range(0, 23) : $urandom_range(0, 63);
      r = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 63) : l + $urandom_range(0, 19);
      t = ($urandom_range(0, 9) == 0) ? 1000 + $urandom_range(0, 23) : $urandom_range(0, 63);
      b = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 63) : t + $urandom_range(0, 19);
      if (r > 1023) r = 1023;
      if (b > 1023) b = 1023;
      set_box($urandom_range(0, NB - 1), l, r, t, b, PIX_W'($urandom),
              $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0);
      ovl_if.box_wr_en    = $urandom_range(0, 7) == 0;
      ovl_if.frame_start  = $urandom_range(0, 39) == 0;
      ovl_if.pix_valid_in = $urandom_range(0, 4) != 0;
      ovl_if.pixel_x      = ($urandom_range(0, 9) == 0) ? COORD_W'($urandom_range(990, 1023))
                                                        : COORD_W'($urandom_range(0, 95));
      ovl_if.pixel_y      = ($urandom_range(0, 9) == 0) ? COORD_W'($urandom_range(990, 1023))
                                                        : COORD_W'($urandom_range(0, 95));
      ovl_if.pixel_in     = PIX_W'($urandom);
      if ($urandom_range(0, 499) == 0) rst = 1'b1;
    end

    @(posedge clk); #1;
    rst = 1'b0;
    idle_inputs();
    repeat (4) @(posedge clk);
    @(negedge clk);
    cmp_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
